// File: rtl/vector_check_engine.sv
// Vector replay and compare engine: streams stored stimulus into a DUT,
// checks masked responses and reports error count, first failure and pass.
module vector_check_engine #(
    parameter int IN_W       = 2,
    parameter int OUT_W      = 1,
    parameter int DEPTH      = 32,
    parameter int AW         = 5,
    parameter int CNT_W      = 11,
    parameter int SETTLE_CYC = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load_en,
    input  logic [AW-1:0]           load_addr,
    input  logic [IN_W+2*OUT_W-1:0] load_data,
    input  logic [AW:0]             num_vec,
    input  logic                    stop_on_err,
    input  logic                    start,
    output logic [IN_W-1:0]         dut_in,
    input  logic [OUT_W-1:0]        dut_out,
    output logic                    busy,
    output logic                    done,
    output logic                    pass,
    output logic                    err_pulse,
    output logic [CNT_W-1:0]        err_cnt,
    output logic                    first_err_valid,
    output logic [AW-1:0]           first_err_idx
);

    localparam int VW = IN_W + 2 * OUT_W;
    localparam int SW = $clog2(SETTLE_CYC + 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_APPLY = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_CHECK = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [AW:0] ONE_N = {{AW{1'b0}}, 1'b1};

    logic [VW-1:0]    mem_q [DEPTH];
    logic [VW-1:0]    rd_q;

    logic [2:0]       state_q, state_d;
    logic [AW-1:0]    idx_q, idx_d;
    logic [AW:0]      nvec_q, nvec_d;
    logic             stop_q, stop_d;
    logic [SW-1:0]    cnt_q, cnt_d;
    logic [OUT_W-1:0] exp_q, exp_d;
    logic [OUT_W-1:0] mask_q, mask_d;
    logic [IN_W-1:0]  din_q, din_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic             errp_q, errp_d;
    logic [CNT_W-1:0] errc_q, errc_d;
    logic             fev_q, fev_d;
    logic [AW-1:0]    fei_q, fei_d;
    logic             mism;
    logic             last;

    assign mism = |((dut_out ^ exp_q) & mask_q);
    assign last = ({1'b0, idx_q} == (nvec_q - ONE_N));

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        nvec_d  = nvec_q;
        stop_d  = stop_q;
        cnt_d   = cnt_q;
        exp_d   = exp_q;
        mask_d  = mask_q;
        din_d   = din_q;
        busy_d  = busy_q;
        done_d  = done_q;
        pass_d  = pass_q;
        errp_d  = 1'b0;
        errc_d  = errc_q;
        fev_d   = fev_q;
        fei_d   = fei_q;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    nvec_d = num_vec;
                    stop_d = stop_on_err;
                    idx_d  = '0;
                    errc_d = '0;
                    fev_d  = 1'b0;
                    fei_d  = '0;
                    done_d = 1'b0;
                    pass_d = 1'b0;
                    if (num_vec == '0) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        pass_d  = 1'b1;
                    end else begin
                        state_d = S_APPLY;
                        busy_d  = 1'b1;
                    end
                end
            end
            S_APPLY: begin
                din_d   = rd_q[VW-1 -: IN_W];
                exp_d   = rd_q[2*OUT_W-1 -: OUT_W];
                mask_d  = rd_q[OUT_W-1:0];
                cnt_d   = SW'(SETTLE_CYC);
                state_d = S_WAIT;
            end
            S_WAIT: begin
                cnt_d = cnt_q - SW'(1);
                if (cnt_q == SW'(1)) state_d = S_CHECK;
            end
            S_CHECK: begin
                if (mism) begin
                    errc_d = (&errc_q) ? errc_q : errc_q + CNT_W'(1);
                    errp_d = 1'b1;
                    if (!fev_q) begin
                        fev_d = 1'b1;
                        fei_d = idx_q;
                    end
                end
                if ((mism && stop_q) || last) begin
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (errc_d == '0);
                end else begin
                    idx_d   = idx_q + AW'(1);
                    state_d = S_APPLY;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            nvec_q  <= '0;
            stop_q  <= 1'b0;
            cnt_q   <= '0;
            exp_q   <= '0;
            mask_q  <= '0;
            din_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            errp_q  <= 1'b0;
            errc_q  <= '0;
            fev_q   <= 1'b0;
            fei_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            nvec_q  <= nvec_d;
            stop_q  <= stop_d;
            cnt_q   <= cnt_d;
            exp_q   <= exp_d;
            mask_q  <= mask_d;
            din_q   <= din_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            errp_q  <= errp_d;
            errc_q  <= errc_d;
            fev_q   <= fev_d;
            fei_q   <= fei_d;
        end
    end

    // Read follows the next index so APPLY always sees the word for idx_q
    always_ff @(posedge clk) begin
        if (load_en && !busy_q) mem_q[load_addr] <= load_data;
        rd_q <= mem_q[idx_d];
    end

    assign dut_in          = din_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign pass            = pass_q;
    assign err_pulse       = errp_q;
    assign err_cnt         = errc_q;
    assign first_err_valid = fev_q;
    assign first_err_idx   = fei_q;

endmodule

// File: tb/tb_vector_check_engine.sv
// Bench for vector_check_engine: directed runs against XOR/OR/AND gates,
// checked every cycle against a timeline model of the run.
module tb_vector_check_engine;

    localparam int IN_W  = 2;
    localparam int OUT_W = 1;
    localparam int DEPTH = 32;
    localparam int AW    = 5;
    localparam int CNT_W = 4;
    localparam int VW    = IN_W + 2 * OUT_W;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset;
    logic             load_en;
    logic [AW-1:0]    load_addr;
    logic [VW-1:0]    load_data;
    logic [AW:0]      num_vec;
    logic             stop_on_err;
    logic             start;
    logic [IN_W-1:0]  dut_in;
    logic [OUT_W-1:0] dut_out;
    logic             busy;
    logic             done;
    logic             pass;
    logic             err_pulse;
    logic [CNT_W-1:0] err_cnt;
    logic             first_err_valid;
    logic [AW-1:0]    first_err_idx;

    int checks   = 0;
    int failures = 0;
    int mode     = 0;
    int done_t;
    int pulses;
    logic [VW-1:0]   tbm [DEPTH];
    logic [IN_W-1:0] last_stim = '0;

    always #5 clk = ~clk;

    vector_check_engine #(
        .IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH), .AW(AW),
        .CNT_W(CNT_W), .SETTLE_CYC(1)
    ) dut (
        .clk(clk), .reset(reset), .load_en(load_en),
        .load_addr(load_addr), .load_data(load_data),
        .num_vec(num_vec), .stop_on_err(stop_on_err), .start(start),
        .dut_in(dut_in), .dut_out(dut_out), .busy(busy), .done(done),
        .pass(pass), .err_pulse(err_pulse), .err_cnt(err_cnt),
        .first_err_valid(first_err_valid), .first_err_idx(first_err_idx)
    );

    function automatic logic fdut(input int m, input logic [1:0] s);
        case (m)
            0:       return s[0] ^ s[1];
            1:       return s[0] | s[1];
            default: return s[0] & s[1];
        endcase
    endfunction

    always_comb dut_out = fdut(mode, dut_in);

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic load(input int a, input logic [VW-1:0] w);
        @(negedge clk);
        load_en   = 1'b1;
        load_addr = AW'(a);
        load_data = w;
        @(negedge clk);
        load_en = 1'b0;
        tbm[a]  = w;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_din"}, dut_in, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_pass"}, pass, 0);
        chk({tag, "_pulse"}, err_pulse, 0);
        chk({tag, "_cnt"}, err_cnt, 0);
        chk({tag, "_fev"}, first_err_valid, 0);
        chk({tag, "_fei"}, first_err_idx, 0);
    endtask

    // Runs n vectors; t counts edges from the one that samples start
    task automatic run(input int n, input bit stop, input bit hold,
                       input bit poke);
        int mm [DEPTH];
        int e, tot, c, ce, fi, k;
        logic [IN_W-1:0] ed;
        logic ep;
        e   = n;
        tot = 0;
        for (int i = 0; i < n; i++)
            mm[i] = int'((fdut(mode, tbm[i][3:2]) ^ tbm[i][1]) & tbm[i][0]);
        if (stop)
            for (int i = n - 1; i >= 0; i--)
                if (mm[i] != 0) e = i + 1;
        for (int i = 0; i < e; i++) tot += mm[i];
        @(negedge clk);
        num_vec     = (AW + 1)'(n);
        stop_on_err = stop;
        start       = 1'b1;
        done_t      = 0;
        pulses      = 0;
        for (int t = 1; t <= 3 * e + 3; t++) begin
            @(negedge clk);
            if (t == (hold ? 5 : 1)) start = 1'b0;
            if (poke && t == 3) begin
                load_en   = 1'b1;
                load_addr = AW'(1);
                load_data = 4'b0101;
            end
            if (poke && t == 4) load_en = 1'b0;
            c  = ((t - 1) / 3 < e) ? (t - 1) / 3 : e;
            ce = 0;
            fi = -1;
            for (int i = 0; i < c; i++) begin
                ce += mm[i];
                if (mm[i] != 0 && fi < 0) fi = i;
            end
            if (t >= 2 && e > 0) begin
                k  = ((t - 2) / 3 < e - 1) ? (t - 2) / 3 : e - 1;
                ed = tbm[k][3:2];
            end else begin
                ed = last_stim;
            end
            ep = 1'b0;
            if (t >= 4 && (t - 1) % 3 == 0 && (t - 1) / 3 <= e)
                ep = (mm[(t - 1) / 3 - 1] != 0);
            chk("busy", busy, (t <= 3 * e) ? 1 : 0);
            chk("done", done, (t >= 3 * e + 1) ? 1 : 0);
            chk("pass", pass, (t >= 3 * e + 1 && tot == 0) ? 1 : 0);
            chk("dut_in", dut_in, ed);
            chk("err_pulse", err_pulse, ep);
            chk("err_cnt", err_cnt, (ce > CMAX) ? CMAX : ce);
            chk("fev", first_err_valid, (fi >= 0) ? 1 : 0);
            chk("fei", first_err_idx, (fi >= 0) ? fi : 0);
            if (done && done_t == 0) done_t = t;
            pulses += int'(err_pulse);
        end
        if (e > 0) last_stim = tbm[e - 1][3:2];
    endtask

    initial begin
        reset       = 1'b1;
        load_en     = 1'b0;
        load_addr   = '0;
        load_data   = '0;
        num_vec     = '0;
        stop_on_err = 1'b0;
        start       = 1'b0;
        repeat (2) @(negedge clk);
        chk_reset_vals("rst");
        reset = 1'b0;

        load(0, 4'b0001);
        load(1, 4'b0111);
        load(2, 4'b1011);
        load(3, 4'b1101);

        mode = 0;
        run(4, 0, 0, 0);
        chk("xor_done_t", done_t, 13);
        chk("xor_pass", pass, 1);
        chk("xor_cnt", err_cnt, 0);
        chk("xor_fev", first_err_valid, 0);
        chk("xor_din", dut_in, 2'b11);

        mode = 1;
        run(4, 0, 0, 0);
        chk("or_pulses", pulses, 1);
        chk("or_cnt", err_cnt, 1);
        chk("or_fei", first_err_idx, 3);
        chk("or_pass", pass, 0);
        chk("or_done", done, 1);

        load(3, 4'b1100);
        run(4, 0, 0, 0);
        chk("mask_cnt", err_cnt, 0);
        chk("mask_pass", pass, 1);
        load(3, 4'b1101);

        mode = 2;
        run(4, 1, 0, 0);
        chk("and_done_t", done_t, 7);
        chk("and_cnt", err_cnt, 1);
        chk("and_fei", first_err_idx, 1);
        chk("and_din", dut_in, 2'b01);

        mode = 0;
        @(negedge clk);
        num_vec     = 6'd4;
        stop_on_err = 1'b0;
        start       = 1'b1;
        for (int t = 1; t <= 8; t++) begin
            @(negedge clk);
            if (t == 1) start = 1'b0;
        end
        reset = 1'b1;
        @(negedge clk);
        chk_reset_vals("midrst");
        reset     = 1'b0;
        last_stim = '0;
        run(4, 0, 0, 0);
        chk("rerun_pass", pass, 1);
        chk("rerun_done_t", done_t, 13);

        run(0, 0, 0, 0);
        chk("zero_done_t", done_t, 1);
        chk("zero_pass", pass, 1);

        run(4, 0, 0, 1);
        run(4, 0, 1, 0);
        chk("poke_cnt", err_cnt, 0);
        chk("poke_pass", pass, 1);

        for (int i = 0; i < 20; i++)
            load(i, {2'(i), ~fdut(0, 2'(i)), 1'b1});
        run(20, 0, 0, 0);
        chk("sat_cnt", err_cnt, CMAX);
        chk("sat_fei", first_err_idx, 0);
        chk("sat_pulses", pulses, 20);
        chk("sat_done_t", done_t, 61);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
